// File: rtl/uart_io_pkg.sv
// -----------------------------------------------------------------------------
// lib_uart: shared types and constants for the uart_io byte I/O responder.
//   TX_STATE    : transmit FSM states
//   RX_STATE    : receive FSM states
//   CLK_PER_BIT : default clock cycles per UART bit
//   fn_cnt_w    : bit-timer counter width for a given cycles-per-bit value
// -----------------------------------------------------------------------------
package lib_uart;

   localparam int unsigned CLK_PER_BIT = 868;

   typedef enum logic [1:0] {
      T_IDLE,
      T_START,
      T_DATA,
      T_STOP
   } TX_STATE;

   typedef enum logic [2:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_STOP,
      R_WAIT
   } RX_STATE;

   // Width needed to hold 0 .. cpb-1; never below one bit.
   function automatic int unsigned fn_cnt_w(input int unsigned cpb);
      return (cpb > 1) ? $clog2(cpb) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core: 8N1 UART receiver.
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   uart_rx_i    : serial input, asynchronous to clk
//   rx_byte_o    : assembled byte, valid while rx_valid_o is high
//   rx_valid_o   : one-cycle pulse on a correctly framed byte (stop bit = 1)
// The line is double-flopped before use. A start edge is confirmed at mid-bit,
// then data and stop are sampled every CLK_PER_BIT cycles from there.
// -----------------------------------------------------------------------------
module uart_rx_core
   import lib_uart::*;
#(
   parameter int unsigned CLK_PER_BIT = lib_uart::CLK_PER_BIT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx_i,
   output logic [7:0] rx_byte_o,
   output logic       rx_valid_o
);

   localparam int unsigned HALF_BIT = CLK_PER_BIT / 2;
   localparam int unsigned CntW     = fn_cnt_w(CLK_PER_BIT);
   localparam logic [CntW-1:0] CntMax  = CntW'(CLK_PER_BIT - 1);
   localparam logic [CntW-1:0] HalfMax = CntW'(HALF_BIT - 1);

   logic [1:0]      sync_q;
   logic            rx_s;
   RX_STATE         rx_state_q;
   logic [CntW-1:0] rx_cnt_q;
   logic [2:0]      rx_idx_q;
   logic [7:0]      rx_shift_q;

   assign rx_s = sync_q[1];

   // Synchroniser resets to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], uart_rx_i};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q <= R_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         case (rx_state_q)
            R_IDLE: begin
               if (!rx_s) begin
                  rx_state_q <= R_START;
                  rx_cnt_q   <= '0;
               end
            end
            R_START: begin
               if (rx_cnt_q == HalfMax) begin
                  rx_cnt_q <= '0;
                  rx_idx_q <= '0;
                  // Line high again at mid start bit means it was only a glitch.
                  rx_state_q <= rx_s ? R_IDLE : R_DATA;
               end else begin
                  rx_cnt_q <= rx_cnt_q + CntW'(1);
               end
            end
            R_DATA: begin
               if (rx_cnt_q == CntMax) begin
                  rx_cnt_q   <= '0;
                  rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                  if (rx_idx_q == 3'd7) begin
                     rx_state_q <= R_STOP;
                  end else begin
                     rx_idx_q <= rx_idx_q + 3'd1;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q + CntW'(1);
               end
            end
            R_STOP: begin
               if (rx_cnt_q == CntMax) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= rx_s ? R_IDLE : R_WAIT;
               end else begin
                  rx_cnt_q <= rx_cnt_q + CntW'(1);
               end
            end
            R_WAIT: begin
               // Framing error: hold off until the line is back at idle.
               if (rx_s) begin
                  rx_state_q <= R_IDLE;
               end
            end
            default: begin
               rx_state_q <= R_IDLE;
               rx_cnt_q   <= '0;
            end
         endcase
      end
   end

   // Valid on the stop-sample cycle so the consumer captures on that same edge.
   assign rx_valid_o = (rx_state_q == R_STOP) && (rx_cnt_q == CntMax) && rx_s;
   assign rx_byte_o  = rx_shift_q;

endmodule

// File: rtl/uart_io.sv
// -----------------------------------------------------------------------------
// uart_io: CPU-side byte I/O responder with an 8N1 UART.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   w_req_i    : CPU write strobe (one-cycle pulse)
//   w_data_i   : byte to transmit, valid with w_req_i
//   w_busy_o   : transmitter occupied; writes while high are dropped
//   r_data_o   : last correctly framed received byte
//   intr_o     : receive interrupt request (level)
//   ack_i      : interrupt acknowledge (one-cycle pulse)
//   uart_tx_o  : serial output, idle high
//   uart_rx_i  : serial input, asynchronous to clk
// -----------------------------------------------------------------------------
module uart_io
   import lib_uart::*;
#(
   parameter int unsigned CLK_PER_BIT = lib_uart::CLK_PER_BIT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       w_req_i,
   input  logic [7:0] w_data_i,
   output logic       w_busy_o,
   output logic [7:0] r_data_o,
   output logic       intr_o,
   input  logic       ack_i,
   output logic       uart_tx_o,
   input  logic       uart_rx_i
);

   localparam int unsigned CntW = fn_cnt_w(CLK_PER_BIT);
   localparam logic [CntW-1:0] CntMax = CntW'(CLK_PER_BIT - 1);

   TX_STATE         tx_state_q;
   logic [CntW-1:0] tx_cnt_q;
   logic [2:0]      tx_idx_q;
   logic [7:0]      tx_shift_q;
   logic            uart_tx_q;
   logic            w_busy_q;

   logic [7:0]      rx_byte;
   logic            rx_valid;
   logic [7:0]      r_data_d, r_data_q;
   logic            intr_d, intr_q;

   // ---------------------------------------------------------------------------
   // Transmit FSM: line and busy are registered so they change on the same edges
   // as the state.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= T_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         uart_tx_q  <= 1'b1;
         w_busy_q   <= 1'b0;
      end else begin
         case (tx_state_q)
            T_IDLE: begin
               if (w_req_i) begin
                  tx_shift_q <= w_data_i;
                  tx_cnt_q   <= '0;
                  uart_tx_q  <= 1'b0;
                  w_busy_q   <= 1'b1;
                  tx_state_q <= T_START;
               end
            end
            T_START: begin
               if (tx_cnt_q == CntMax) begin
                  tx_cnt_q   <= '0;
                  tx_idx_q   <= '0;
                  uart_tx_q  <= tx_shift_q[0];
                  tx_state_q <= T_DATA;
               end else begin
                  tx_cnt_q <= tx_cnt_q + CntW'(1);
               end
            end
            T_DATA: begin
               if (tx_cnt_q == CntMax) begin
                  tx_cnt_q <= '0;
                  if (tx_idx_q == 3'd7) begin
                     uart_tx_q  <= 1'b1;
                     tx_state_q <= T_STOP;
                  end else begin
                     tx_idx_q   <= tx_idx_q + 3'd1;
                     tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                     uart_tx_q  <= tx_shift_q[1];
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + CntW'(1);
               end
            end
            T_STOP: begin
               if (tx_cnt_q == CntMax) begin
                  tx_cnt_q   <= '0;
                  w_busy_q   <= 1'b0;
                  tx_state_q <= T_IDLE;
               end else begin
                  tx_cnt_q <= tx_cnt_q + CntW'(1);
               end
            end
            default: begin
               tx_state_q <= T_IDLE;
               tx_cnt_q   <= '0;
               uart_tx_q  <= 1'b1;
               w_busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign uart_tx_o = uart_tx_q;
   assign w_busy_o  = w_busy_q;

   // ---------------------------------------------------------------------------
   // Receive path
   // ---------------------------------------------------------------------------
   uart_rx_core #(
      .CLK_PER_BIT(CLK_PER_BIT)
   ) u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart_rx_i (uart_rx_i),
      .rx_byte_o (rx_byte),
      .rx_valid_o(rx_valid)
   );

   // New bytes overwrite unconditionally; a set outranks a same-cycle ack.
   always_comb begin
      r_data_d = r_data_q;
      intr_d   = intr_q;
      if (rx_valid) begin
         r_data_d = rx_byte;
         intr_d   = 1'b1;
      end else if (ack_i) begin
         intr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_q <= 8'h00;
         intr_q   <= 1'b0;
      end else begin
         r_data_q <= r_data_d;
         intr_q   <= intr_d;
      end
   end

   assign r_data_o = r_data_q;
   assign intr_o   = intr_q;

endmodule

// File: tb/tb_uart_io.sv
module tb_uart_io;

   localparam int unsigned Cpb = 8;

   logic       clk;
   logic       rst_n;
   logic       w_req;
   logic [7:0] w_data;
   logic       w_busy;
   logic [7:0] r_data;
   logic       intr;
   logic       ack;
   logic       uart_tx;
   logic       rx_drv;
   logic       lb_en;
   logic       rx_line;

   int n_checks = 0;
   int n_errors = 0;

   assign rx_line = lb_en ? uart_tx : rx_drv;

   uart_io #(
      .CLK_PER_BIT(Cpb)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .w_req_i  (w_req),
      .w_data_i (w_data),
      .w_busy_o (w_busy),
      .r_data_o (r_data),
      .intr_o   (intr),
      .ack_i    (ack),
      .uart_tx_o(uart_tx),
      .uart_rx_i(rx_line)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic write_byte(input logic [7:0] d);
      w_data = d;
      w_req  = 1'b1;
      tick(1);
      w_req  = 1'b0;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
   endtask

   // Drive one 8N1 frame on the RX pin. If ack_at_set, ack is high during the
   // cycle whose closing edge takes the stop sample.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_at_set);
      logic [9:0] fr;
      fr = {stop, d, 1'b0};
      for (int i = 0; i < 9; i++) begin
         rx_drv = fr[i];
         tick(Cpb);
      end
      rx_drv = fr[9];
      tick(6);
      if (ack_at_set) ack = 1'b1;
      tick(1);
      ack = 1'b0;
      tick(1);
      rx_drv = 1'b1;
      tick(Cpb);
   endtask

   task automatic send_glitch();
      rx_drv = 1'b0;
      tick(2);
      rx_drv = 1'b1;
      tick(2 * Cpb);
   endtask

   task automatic wait_busy_low();
      int n;
      n = 0;
      while (w_busy && n < 200) begin
         tick(1);
         n++;
      end
      chk("busy_fall_timeout", {31'd0, w_busy}, 32'd0);
   endtask

   typedef struct {
      int         kind;        // 0 frame, 1 glitch, 2 ack only
      logic [7:0] data;
      logic       stop;
      logic       ack_at_set;
      logic       do_ack;
      logic [7:0] exp_r;
      logic       exp_i;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [9:0] frame;
      int         cur;
      logic [7:0] exp_r;
      logic       exp_i;
      logic [7:0] d;
      logic [7:0] prev;
      logic [7:0] nxt;
      logic       stp;

      vecs[0] = '{0, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1};
      vecs[1] = '{1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0};
      vecs[2] = '{0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
      vecs[3] = '{0, 8'h12, 1'b1, 1'b0, 1'b1, 8'h12, 1'b1};
      vecs[4] = '{0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1};
      vecs[5] = '{0, 8'h22, 1'b1, 1'b1, 1'b0, 8'h22, 1'b1};
      vecs[6] = '{2, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0};
      vecs[7] = '{2, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0};

      rst_n  = 1'b0;
      w_req  = 1'b0;
      w_data = 8'h00;
      ack    = 1'b0;
      rx_drv = 1'b1;
      lb_en  = 1'b0;

      // Reset state
      tick(3);
      chk("rst_tx", {31'd0, uart_tx}, 32'd1);
      chk("rst_busy", {31'd0, w_busy}, 32'd0);
      chk("rst_rdata", {24'd0, r_data}, 32'h00);
      chk("rst_intr", {31'd0, intr}, 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Reset mid-TX aborts asynchronously
      write_byte(8'hA5);
      tick(29);
      chk("midtx_busy_before", {31'd0, w_busy}, 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("midtx_tx_async", {31'd0, uart_tx}, 32'd1);
      chk("midtx_busy_async", {31'd0, w_busy}, 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      chk("midtx_intr_after", {31'd0, intr}, 32'd0);
      chk("midtx_rdata_after", {24'd0, r_data}, 32'h00);
      chk("midtx_tx_idle", {31'd0, uart_tx}, 32'd1);

      // TX A5 bit by bit, with a dropped write at cycle 40
      frame = {1'b1, 8'hA5, 1'b0};
      write_byte(8'hA5);
      cur = 0;
      chk("tx_busy_rise", {31'd0, w_busy}, 32'd1);
      for (int k = 0; k < 10; k++) begin
         if (k == 5) begin
            tick(40 - cur);
            write_byte(8'h5A);
            cur = 41;
         end
         tick(8 * k + 4 - cur);
         cur = 8 * k + 4;
         chk($sformatf("tx_bit%0d", k), {31'd0, uart_tx}, {31'd0, frame[k]});
      end
      tick(79 - cur);
      chk("tx_busy_79", {31'd0, w_busy}, 32'd1);
      tick(1);
      chk("tx_busy_80", {31'd0, w_busy}, 32'd0);
      chk("tx_line_idle", {31'd0, uart_tx}, 32'd1);
      tick(40);
      chk("tx_dropped_busy", {31'd0, w_busy}, 32'd0);
      chk("tx_dropped_line", {31'd0, uart_tx}, 32'd1);

      // RX vectors
      for (int i = 0; i < 8; i++) begin
         case (vecs[i].kind)
            0: send_frame(vecs[i].data, vecs[i].stop, vecs[i].ack_at_set);
            1: send_glitch();
            default: pulse_ack();
         endcase
         chk($sformatf("vec%0d_rdata", i), {24'd0, r_data}, {24'd0, vecs[i].exp_r});
         chk($sformatf("vec%0d_intr", i), {31'd0, intr}, {31'd0, vecs[i].exp_i});
         if (vecs[i].do_ack) begin
            pulse_ack();
            chk($sformatf("vec%0d_ack", i), {31'd0, intr}, 32'd0);
         end
      end

      // Random RX frames against a frame-level model
      exp_r = r_data;
      exp_i = 1'b0;
      for (int i = 0; i < 12; i++) begin
         d   = 8'($urandom);
         stp = ($urandom_range(0, 3) != 0);
         send_frame(d, stp, 1'b0);
         if (stp) begin
            exp_r = d;
            exp_i = 1'b1;
         end
         chk($sformatf("rnd%0d_rdata", i), {24'd0, r_data}, {24'd0, exp_r});
         chk($sformatf("rnd%0d_intr", i), {31'd0, intr}, {31'd0, exp_i});
         if ($urandom_range(0, 1) == 1) begin
            pulse_ack();
            exp_i = 1'b0;
            chk($sformatf("rnd%0d_ack", i), {31'd0, intr}, 32'd0);
         end
      end
      pulse_ack();

      // Loopback: back-to-back writes issued on the first non-busy cycle
      lb_en = 1'b1;
      tick(4);
      prev = 8'hFF;
      write_byte(prev);
      for (int i = 1; i <= 8; i++) begin
         tick($urandom_range(5, 60));
         write_byte(8'($urandom));
         wait_busy_low();
         chk($sformatf("lb%0d_rdata", i), {24'd0, r_data}, {24'd0, prev});
         chk($sformatf("lb%0d_intr", i), {31'd0, intr}, 32'd1);
         if (i < 8) begin
            nxt    = (i == 1) ? 8'h00 : 8'($urandom);
            w_data = nxt;
            w_req  = 1'b1;
            ack    = 1'b1;
            tick(1);
            w_req  = 1'b0;
            ack    = 1'b0;
            chk($sformatf("lb%0d_busy", i), {31'd0, w_busy}, 32'd1);
            chk($sformatf("lb%0d_clr", i), {31'd0, intr}, 32'd0);
            prev = nxt;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
